mem_port_initiator: RTL and testbench

- CPU-side initiator for the RAM unit's second (data) port.
- Accepts one load/store request at a time from the execute stage and checks alignment. Issues the request to the RAM in the cycle the RAM is in its instruction-fetch state, then tracks the RAM's multi-cycle load or read-rewrite store.
- Returns load data or a store acknowledgement through a held valid/ready response, and drives a stall to the pipeline while an access is outstanding.

---
 rtl/mem_port_initiator_if.sv | 47 ++++
 rtl/mem_port_initiator.sv | 130 +++++++++++++
 tb/tb_mem_port_initiator.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_initiator_if.sv
// Bundle of the core-side request/response handshake and the RAM data-port
// signals used by mem_port_initiator.
// master: the initiator's view. slave: the core plus RAM environment's view.
interface mem_port_initiator_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_mode;

    // Core response channel and pipeline stall
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        stall;

    // RAM second (data) port
    logic        ram_idle;
    logic        port2en;
    logic        port2WEn;
    logic [31:0] port2adr;
    logic [31:0] port2i;
    logic [1:0]  memMode;
    logic [31:0] port2o;
    logic        port2avail;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_mode,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_fault, stall,
        input  rsp_ready,
        input  ram_idle, port2o, port2avail,
        output port2en, port2WEn, port2adr, port2i, memMode
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_mode,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_fault, stall,
        output rsp_ready,
        output ram_idle, port2o, port2avail,
        input  port2en, port2WEn, port2adr, port2i, memMode
    );
endinterface

// File: rtl/mem_port_initiator.sv
// CPU-side initiator for the RAM data port. Accepts one load/store at a time,
// rejects misaligned/illegal accesses, issues aligned ones while the RAM sits
// in its fetch state, then tracks the RAM's load or read-rewrite store and
// returns a held valid/ready response. Stalls the pipeline while busy.
module mem_port_initiator #(
    parameter int LOAD_TIMEOUT = 8,
    parameter int STORE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        STORE_WAIT,
        RESP
    } state_t;

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam int SW = $clog2(STORE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOAD_TIMEOUT - 1);
    localparam logic [SW-1:0] STORE_LAST = SW'(STORE_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] st_cnt;
    logic          aligned;
    logic          in_idle;
    logic          accept;

    // Alignment of the incoming request for its access width.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        aligned = 1'b0;
        case (bus.req_mode)
            2'd0:    aligned = (bus.req_addr[1:0] == 2'b00);
            2'd1:    aligned = (bus.req_addr[0] == 1'b0);
            2'd2:    aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
    end

    // Combinational handshake, stall and RAM issue; everything forced low in reset.
    always_comb begin
        in_idle       = (state == IDLE) && !reset;
        bus.req_ready = in_idle && bus.ram_idle;
        accept        = bus.req_ready && bus.req_valid;
        bus.port2en   = accept && aligned;
        bus.port2WEn  = in_idle ? bus.req_we    : 1'b0;
        bus.port2adr  = in_idle ? bus.req_addr  : 32'h0;
        bus.port2i    = in_idle ? bus.req_wdata : 32'h0;
        bus.memMode   = in_idle ? bus.req_mode  : 2'd0;
        bus.stall     = !reset &&
                        ((bus.req_valid && !(state == IDLE && bus.ram_idle)) ||
                         (state != IDLE));
    end

    // Access FSM with registered response; reset drops any pending response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
        if (reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            st_cnt        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!aligned) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_fault <= 1'b1;
                            bus.rsp_rdata <= 32'h0;
                            state         <= RESP;
                        end else if (bus.req_we) begin
                            st_cnt <= '0;
                            state  <= STORE_WAIT;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= LOAD_WAIT;
                        end
                    end
                end

                LOAD_WAIT: begin
                    // Data arriving in the expiry cycle still wins over the timeout.
                    if (bus.port2avail) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b0;
                        bus.rsp_rdata <= bus.port2o;
                        state         <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b1;
                        bus.rsp_rdata <= 32'h0;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                STORE_WAIT: begin
                    // The RAM is busy reading and rewriting; port2avail is not meaningful here.
                    if (st_cnt == STORE_LAST) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b0;
                        bus.rsp_rdata <= 32'h0;
                        state         <= RESP;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Self-checking bench for mem_port_initiator: a small byte-addressed RAM model
// answers issued accesses; expected responses go into a scoreboard queue when a
// request is accepted and are popped when the DUT raises rsp_valid.
module tb_mem_port_initiator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_initiator_if bus ();

    mem_port_initiator #(
        .LOAD_TIMEOUT (8),
        .STORE_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // ---------------- RAM model ----------------
    logic [7:0]  mem [0:255];
    logic [31:0] ld_data;
    int          ld_left = 0;
    int          ram_delay = 0;
    int          en_cnt = 0;
    logic        last_we;
    logic [1:0]  last_mode;

    function automatic logic [31:0] ram_read(input logic [7:0] a, input logic [1:0] m);
        case (m)
            2'd0:    return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
            2'd1:    return {16'h0, mem[8'(a + 1)], mem[a]};
            2'd2:    return {24'h0, mem[a]};
            default: return 32'h0;
        endcase
    endfunction

    // RAM samples its port on the clock; reset restores the preloaded image.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hEF;
            mem[8'h11] <= 8'hBE;
            mem[8'h12] <= 8'hAD;
            mem[8'h13] <= 8'hDE;
            ld_left    <= 0;
        end else if (bus.port2en) begin
            en_cnt    <= en_cnt + 1;
            last_we   <= bus.port2WEn;
            last_mode <= bus.memMode;
            if (bus.port2WEn) begin
                mem[bus.port2adr[7:0]] <= bus.port2i[7:0];
                if (bus.memMode != 2'd2) mem[8'(bus.port2adr[7:0] + 1)] <= bus.port2i[15:8];
                if (bus.memMode == 2'd0) begin
                    mem[8'(bus.port2adr[7:0] + 2)] <= bus.port2i[23:16];
                    mem[8'(bus.port2adr[7:0] + 3)] <= bus.port2i[31:24];
                end
            end else begin
                ld_data <= ram_read(bus.port2adr[7:0], bus.memMode);
                ld_left <= ram_delay + 1;
            end
        end else if (ld_left > 0) begin
            ld_left <= ld_left - 1;
        end
    end

    // Load data is presented for one cycle, ram_delay cycles after the issue cycle's successor.
    always @(negedge clk) begin
        bus.port2avail = (ld_left == 1);
        bus.port2o     = (ld_left == 1) ? ld_data : 32'h0;
    end

    // ---------------- request driver / scoreboard ----------------
    // Called just after a negedge. Drives one request, checks the response and
    // its latency, optionally holds rsp_ready low with a new request pending.
    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mode,
                           input logic [31:0] exp_rdata, input logic exp_fault,
                           input int exp_lat, input int hold);
        exp_t e;
        int   base;
        int   n;
        logic issue;
        issue         = (exp_lat != 1);
        base          = en_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_mode  = mode;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.req_ready) begin
            check({tag, " accept"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        sb.push_back('{rdata: exp_rdata, fault: exp_fault, lat: exp_lat});
        check({tag, " port2en"}, {31'h0, bus.port2en}, {31'h0, issue});
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.rsp_valid) begin
            check({tag, " rsp_valid"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, " rdata"},   bus.rsp_rdata, e.rdata);
        check({tag, " fault"},   {31'h0, bus.rsp_fault}, {31'h0, e.fault});
        check({tag, " latency"}, 32'(n), 32'(e.lat));
        check({tag, " issues"},  32'(en_cnt - base), {31'h0, issue});
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk); #1;
                check({tag, " hold valid"}, {31'h0, bus.rsp_valid}, 32'd1);
                check({tag, " hold rdata"}, bus.rsp_rdata, e.rdata);
                check({tag, " hold stall"}, {31'h0, bus.stall}, 32'd1);
                check({tag, " hold port2en"}, {31'h0, bus.port2en}, 32'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        check({tag, " ready-cycle port2en"}, {31'h0, bus.port2en}, 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check({tag, " consumed"}, {31'h0, bus.rsp_valid}, 32'd0);
        check({tag, " stall off"}, {31'h0, bus.stall}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base0;
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        bus.req_mode  = 2'd0;
        bus.rsp_ready = 1'b0;
        bus.ram_idle  = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("reset req_ready", {31'h0, bus.req_ready}, 32'd0);
        check("reset port2en",   {31'h0, bus.port2en},   32'd0);
        check("reset stall",     {31'h0, bus.stall},     32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);

        run_req("word_load",  1'b0, 32'h10, 32'h0,  2'd0, 32'hDEADBEEF, 1'b0, 2, 0);
        run_req("byte_store", 1'b1, 32'h13, 32'hAB, 2'd2, 32'h0,        1'b0, 3, 0);
        check("store WEn",     {31'h0, last_we},   32'd1);
        check("store memMode", {30'h0, last_mode}, 32'd2);
        run_req("byte_load",  1'b0, 32'h13, 32'h0,  2'd2, 32'h000000AB, 1'b0, 2, 0);
        run_req("word_reload",1'b0, 32'h10, 32'h0,  2'd0, 32'hABADBEEF, 1'b0, 2, 0);
        run_req("half_mis",   1'b0, 32'h11, 32'h0,  2'd1, 32'h0,        1'b1, 1, 0);
        run_req("word_mis",   1'b0, 32'h12, 32'h0,  2'd0, 32'h0,        1'b1, 1, 0);
        run_req("mode3",      1'b0, 32'h00, 32'h0,  2'd3, 32'h0,        1'b1, 1, 0);
        run_req("half_store", 1'b1, 32'h12, 32'h1234, 2'd1, 32'h0,      1'b0, 3, 0);
        run_req("half_load",  1'b0, 32'h12, 32'h0,  2'd1, 32'h00001234, 1'b0, 2, 0);
        run_req("backpress",  1'b0, 32'h10, 32'h0,  2'd0, 32'h1234BEEF, 1'b0, 2, 5);

        // Data in the final wait cycle beats the timeout.
        ram_delay = 7;
        run_req("late_data",  1'b0, 32'h10, 32'h0,  2'd0, 32'h1234BEEF, 1'b0, 9, 0);
        // No data inside the window: timeout fault.
        ram_delay = 8;
        run_req("timeout",    1'b0, 32'h14, 32'h0,  2'd0, 32'h0,        1'b1, 9, 0);
        ram_delay = 0;
        repeat (2) @(negedge clk);

        // RAM busy: request waits without issue.
        base0         = en_cnt;
        bus.ram_idle  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_mode  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy req_ready", {31'h0, bus.req_ready}, 32'd0);
            check("busy stall",     {31'h0, bus.stall},     32'd1);
            check("busy port2en",   {31'h0, bus.port2en},   32'd0);
            @(negedge clk);
        end
        check("busy no issue", 32'(en_cnt - base0), 32'd0);
        bus.ram_idle = 1'b1;
        run_req("busy_load",  1'b0, 32'h10, 32'h0,  2'd0, 32'h1234BEEF, 1'b0, 2, 0);

        // Reset while a store is in flight.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h55AA55AA;
        bus.req_mode  = 2'd0;
        #1;
        check("rst_store accept", {31'h0, bus.port2en}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("rst_store in flight", {31'h0, bus.stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst cycle port2en", {31'h0, bus.port2en}, 32'd0);
        check("rst cycle stall",   {31'h0, bus.stall},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-rst rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("post-rst stall",     {31'h0, bus.stall},     32'd0);
        check("post-rst port2en",   {31'h0, bus.port2en},   32'd0);
        check("post-rst req_ready", {31'h0, bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("post-rst no response", {31'h0, bus.rsp_valid}, 32'd0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
